// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//    Sequential hazard and stall controller for the 5-stage MIPS pipeline.
//    It tracks in-flight destinations in a shift-register scoreboard and
//    detects load-use and MULT/DIV (HI/LO busy) hazards. It freezes the pipe on
//    a data-cache miss and flushes IF/ID on a resolved redirect. On SYSCALL it
//    drains the pipe, then holds a sticky halt.
//
// Ports
//    clk, rst_b      rising-edge clock, asynchronous active-low reset
//    inst_id         instruction currently in ID
//    id_valid        inst_id is a real instruction (0 = bubble)
//    mem_access      MEM stage holds a load/store
//    mem_hit         cache hit for that MEM access
//    redirect        taken branch / J / JAL / JR resolved this cycle
//    pc_we           PC write enable
//    ifid_we         IF/ID register write enable
//    id_bubble       inject NOP into ID/EX instead of the ID instruction
//    flush           clear IF/ID
//    freeze          hold every post-ID pipeline register
//    halted          sticky halt indication
//    stall_cnt       saturating count of cycles with pc_we=0
module pipeline_hazard_ctrl #(
   parameter int unsigned PIPE_DEPTH = 3,
   parameter int unsigned MULDIV_LAT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [31:0]      inst_id,
   input  logic             id_valid,
   input  logic             mem_access,
   input  logic             mem_hit,
   input  logic             redirect,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             id_bubble,
   output logic             flush,
   output logic             freeze,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [5:0] OpSpecial = 6'h00;
   localparam logic [5:0] OpRegimm  = 6'h01;
   localparam logic [5:0] OpJal     = 6'h03;
   localparam logic [5:0] OpBeq     = 6'h04;
   localparam logic [5:0] OpBne     = 6'h05;
   localparam logic [5:0] OpBlez    = 6'h06;
   localparam logic [5:0] OpBgtz    = 6'h07;
   localparam logic [5:0] OpAddi    = 6'h08;
   localparam logic [5:0] OpAddiu   = 6'h09;
   localparam logic [5:0] OpSlti    = 6'h0a;
   localparam logic [5:0] OpSltiu   = 6'h0b;
   localparam logic [5:0] OpAndi    = 6'h0c;
   localparam logic [5:0] OpOri     = 6'h0d;
   localparam logic [5:0] OpXori    = 6'h0e;
   localparam logic [5:0] OpLui     = 6'h0f;
   localparam logic [5:0] OpLb      = 6'h20;
   localparam logic [5:0] OpLw      = 6'h23;
   localparam logic [5:0] OpSb      = 6'h28;
   localparam logic [5:0] OpSw      = 6'h2b;

   localparam logic [5:0] FnJr      = 6'h08;
   localparam logic [5:0] FnSyscall = 6'h0c;
   localparam logic [5:0] FnMult    = 6'h18;
   localparam logic [5:0] FnDiv     = 6'h1a;

   localparam logic [3:0] MdLat     = 4'(MULDIV_LAT);
   localparam logic [2:0] DrainInit = 3'(PIPE_DEPTH);

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       is_load;
   } sb_entry_t;

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   // ---------------------------------------------------------------------
   // ID decode
   // ---------------------------------------------------------------------
   logic [5:0] opcode, funct;
   logic [4:0] rs, rt, rd;
   logic       raw_use_rs, raw_use_rt;
   logic       use_rs, use_rt;
   logic [4:0] dec_dest;
   logic       dec_load, dec_muldiv, dec_syscall;
   logic       unused_shamt;

   assign opcode = inst_id[31:26];
   assign rs     = inst_id[25:21];
   assign rt     = inst_id[20:16];
   assign rd     = inst_id[15:11];
   assign funct  = inst_id[5:0];
   assign unused_shamt = ^inst_id[10:6];

   always_comb begin
      raw_use_rs  = 1'b0;
      raw_use_rt  = 1'b0;
      dec_dest    = 5'd0;
      dec_load    = 1'b0;
      dec_muldiv  = 1'b0;
      dec_syscall = 1'b0;
      case (opcode)
         OpSpecial: begin
            raw_use_rs = 1'b1;
            raw_use_rt = 1'b1;
            dec_dest   = rd;
            case (funct)
               FnJr:          dec_dest = 5'd0;
               FnMult, FnDiv: begin
                  dec_dest   = 5'd0;
                  dec_muldiv = 1'b1;
               end
               FnSyscall: begin
                  raw_use_rs  = 1'b0;
                  raw_use_rt  = 1'b0;
                  dec_dest    = 5'd0;
                  dec_syscall = 1'b1;
               end
               default: ;
            endcase
         end
         OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori: begin
            raw_use_rs = 1'b1;
            dec_dest   = rt;
         end
         OpLui: dec_dest = rt;
         OpLw, OpLb: begin
            raw_use_rs = 1'b1;
            dec_dest   = rt;
            dec_load   = 1'b1;
         end
         OpSw, OpSb, OpBeq, OpBne: begin
            raw_use_rs = 1'b1;
            raw_use_rt = 1'b1;
         end
         OpRegimm, OpBlez, OpBgtz: raw_use_rs = 1'b1;
         OpJal: dec_dest = 5'd31;
         default: ;
      endcase
   end

   // $0 is hardwired, so it can never carry a dependency.
   assign use_rs = raw_use_rs & (rs != 5'd0);
   assign use_rt = raw_use_rt & (rt != 5'd0);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   sb_entry_t        sb_q [PIPE_DEPTH];
   sb_entry_t        sb_d [PIPE_DEPTH];
   logic [3:0]       md_cnt_q, md_cnt_d;
   logic [2:0]       drain_q, drain_d;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             unused_sb_tail;

   // Only EX (entry 0) feeds the load-use check; later entries just age out.
   assign unused_sb_tail = ^sb_q[PIPE_DEPTH-1];

   // ---------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------
   logic miss, load_use, md_busy, issue;

   assign miss     = mem_access & ~mem_hit;
   // Dest $0 is stored for "no destination"; masked sources never match it.
   assign load_use = id_valid & sb_q[0].valid & sb_q[0].is_load &
                     ((use_rs & (rs == sb_q[0].dest)) | (use_rt & (rt == sb_q[0].dest)));
   assign md_busy  = id_valid & (md_cnt_q != 4'd0);

   // ---------------------------------------------------------------------
   // Pipeline controls. Outputs are forced to their reset values while
   // rst_b is low so the pipe sees a clean RUN state immediately.
   // ---------------------------------------------------------------------
   always_comb begin
      pc_we     = 1'b1;
      ifid_we   = 1'b1;
      id_bubble = 1'b0;
      flush     = 1'b0;
      freeze    = 1'b0;
      halted    = 1'b0;
      issue     = 1'b0;
      if (rst_b) begin
         unique case (state_q)
            StHalted: begin
               halted  = 1'b1;
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               freeze  = 1'b1;
            end
            StDrain: begin
               // Nothing follows SYSCALL, so a redirect cannot be legitimate here.
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               if (miss) begin
                  freeze = 1'b1;
               end else begin
                  id_bubble = 1'b1;
               end
            end
            default: begin
               if (miss) begin
                  // Miss beats redirect: EX is frozen so the redirect re-presents.
                  freeze  = 1'b1;
                  pc_we   = 1'b0;
                  ifid_we = 1'b0;
               end else if (redirect) begin
                  flush = 1'b1;
               end else if (md_busy | load_use) begin
                  pc_we     = 1'b0;
                  ifid_we   = 1'b0;
                  id_bubble = 1'b1;
               end else begin
                  issue = id_valid;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------
   always_comb begin
      sb_d     = sb_q;
      md_cnt_d = md_cnt_q;
      drain_d  = drain_q;
      state_d  = state_q;
      if (!freeze) begin
         for (int i = int'(PIPE_DEPTH) - 1; i >= 1; i--) begin
            sb_d[i] = sb_q[i-1];
         end
         sb_d[0].valid   = issue;
         sb_d[0].dest    = issue ? dec_dest : 5'd0;
         sb_d[0].is_load = issue & dec_load;

         if (issue && dec_muldiv) begin
            md_cnt_d = MdLat;
         end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
         end

         if (state_q == StDrain) begin
            if (drain_q != 3'd0) begin
               drain_d = drain_q - 3'd1;
            end
            // A still-busy MULT/DIV keeps us draining until HI/LO settles.
            if ((drain_d == 3'd0) && (md_cnt_d == 4'd0)) begin
               state_d = StHalted;
            end
         end

         if (issue && dec_syscall) begin
            state_d = StDrain;
            drain_d = DrainInit;
         end
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
            sb_q[i] <= '0;
         end
         md_cnt_q    <= 4'd0;
         drain_q     <= 3'd0;
         state_q     <= StRun;
         stall_cnt_q <= '0;
      end else begin
         sb_q        <= sb_d;
         md_cnt_q    <= md_cnt_d;
         drain_q     <= drain_d;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
   localparam int PD = 3;
   localparam int ML = 4;
   localparam int CW = 16;
   localparam int MRun = 0, MDrain = 1, MHalt = 2;

   logic          clk = 1'b0;
   logic          rst_b;
   logic [31:0]   inst_id;
   logic          id_valid, mem_access, mem_hit, redirect;
   logic          pc_we, ifid_we, id_bubble, flush, freeze, halted;
   logic [CW-1:0] stall_cnt;

   pipeline_hazard_ctrl #(.PIPE_DEPTH(PD), .MULDIV_LAT(ML), .CNT_W(CW)) dut (
      .clk(clk), .rst_b(rst_b), .inst_id(inst_id), .id_valid(id_valid),
      .mem_access(mem_access), .mem_hit(mem_hit), .redirect(redirect),
      .pc_we(pc_we), .ifid_we(ifid_we), .id_bubble(id_bubble), .flush(flush),
      .freeze(freeze), .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit rs_u;
      bit rt_u;
      int rs;
      int rt;
      int dest;
      bit load;
      bit md;
      bit sys;
      bit valid;
   } dec_t;

   // Reference model: in-flight instructions as a queue, newest in front.
   dec_t inflight[$];
   int   m_md, m_mode, m_drain, m_stalls;
   dec_t m_dec;
   bit   m_issue;
   bit   e_pc, e_ifid, e_bub, e_fl, e_frz, e_halt;

   function automatic dec_t decode(logic [31:0] i);
      dec_t d = '{default: 0};
      int op = int'(i[31:26]);
      int fn = int'(i[5:0]);
      d.rs = int'(i[25:21]);
      d.rt = int'(i[20:16]);
      if (op == 0) begin
         d.rs_u = 1; d.rt_u = 1; d.dest = int'(i[15:11]);
         if (fn == 8) d.dest = 0;
         if (fn == 24 || fn == 26) begin d.dest = 0; d.md = 1; end
         if (fn == 12) begin d.rs_u = 0; d.rt_u = 0; d.dest = 0; d.sys = 1; end
      end else if (op >= 8 && op <= 14) begin
         d.rs_u = 1; d.dest = d.rt;
      end else if (op == 15) begin
         d.dest = d.rt;
      end else if (op == 35 || op == 32) begin
         d.rs_u = 1; d.dest = d.rt; d.load = 1;
      end else if (op == 43 || op == 40 || op == 4 || op == 5) begin
         d.rs_u = 1; d.rt_u = 1;
      end else if (op == 1 || op == 6 || op == 7) begin
         d.rs_u = 1;
      end else if (op == 3) begin
         d.dest = 31;
      end
      if (d.rs == 0) d.rs_u = 0;
      if (d.rt == 0) d.rt_u = 0;
      return d;
   endfunction

   function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] itype(int op, int rs, int rt);
      return {6'(op), 5'(rs), 5'(rt), 16'h0010};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      inflight = {};
      m_md = 0; m_mode = MRun; m_drain = 0; m_stalls = 0;
   endtask

   task automatic model_eval();
      bit miss, lu, busy;
      dec_t ex;
      m_dec   = decode(inst_id);
      miss    = mem_access && !mem_hit;
      lu      = 0;
      if (inflight.size() > 0) begin
         ex = inflight[0];
         lu = id_valid && ex.valid && ex.load && ex.dest != 0 &&
              ((m_dec.rs_u && m_dec.rs == ex.dest) || (m_dec.rt_u && m_dec.rt == ex.dest));
      end
      busy = id_valid && (m_md > 0);
      {e_pc, e_ifid, e_bub, e_fl, e_frz, e_halt} = 6'b110000;
      m_issue = 0;
      if (m_mode == MHalt)        {e_pc, e_ifid, e_bub, e_fl, e_frz, e_halt} = 6'b000011;
      else if (miss)              {e_pc, e_ifid, e_bub, e_fl, e_frz, e_halt} = 6'b000010;
      else if (m_mode == MDrain)  {e_pc, e_ifid, e_bub, e_fl, e_frz, e_halt} = 6'b001000;
      else if (redirect)          {e_pc, e_ifid, e_bub, e_fl, e_frz, e_halt} = 6'b110100;
      else if (lu || busy)        {e_pc, e_ifid, e_bub, e_fl, e_frz, e_halt} = 6'b001000;
      else                        m_issue = id_valid;
   endtask

   task automatic model_advance();
      dec_t e;
      if (!e_pc && m_stalls < (1 << CW) - 1) m_stalls++;
      if (e_frz) return;
      e = m_dec;
      e.valid = m_issue;
      inflight.push_front(e);
      if (inflight.size() > PD) void'(inflight.pop_back());
      if (m_issue && m_dec.md) m_md = ML;
      else if (m_md > 0) m_md--;
      if (m_mode == MDrain) begin
         if (m_drain > 0) m_drain--;
         if (m_drain == 0 && m_md == 0) m_mode = MHalt;
      end
      if (m_issue && m_dec.sys) begin
         m_mode  = MDrain;
         m_drain = PD;
      end
   endtask

   task automatic check_outputs(string tag);
      check({tag, ".pc_we"},     32'(pc_we),     32'(e_pc));
      check({tag, ".ifid_we"},   32'(ifid_we),   32'(e_ifid));
      check({tag, ".id_bubble"}, 32'(id_bubble), 32'(e_bub));
      check({tag, ".flush"},     32'(flush),     32'(e_fl));
      check({tag, ".freeze"},    32'(freeze),    32'(e_frz));
      check({tag, ".halted"},    32'(halted),    32'(e_halt));
      check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stalls));
   endtask

   task automatic step(string tag, logic [31:0] inst, bit v, bit ma, bit mh, bit rd);
      @(negedge clk);
      inst_id = inst; id_valid = v; mem_access = ma; mem_hit = mh; redirect = rd;
      #1;
      model_eval();
      check_outputs(tag);
      model_advance();
   endtask

   task automatic do_reset();
      @(negedge clk);
      inst_id = 32'd0; id_valid = 0; mem_access = 0; mem_hit = 1; redirect = 0;
      rst_b = 0;
      #1;
      model_reset();
      model_eval();
      check_outputs("reset");
      #1 rst_b = 1;
   endtask

   localparam logic [31:0] NOP = 32'd0;
   logic [31:0] lw8, add_dep, add_ind, mult, sysc, lw0, add_r0;
   int base;

   initial begin
      rst_b = 1; inst_id = 0; id_valid = 0; mem_access = 0; mem_hit = 1; redirect = 0;
      model_reset();
      lw8     = itype(35, 1, 8);
      lw0     = itype(35, 1, 0);
      add_dep = rtype(8, 1, 9, 32);
      add_r0  = rtype(0, 1, 9, 32);
      add_ind = rtype(2, 3, 4, 32);
      mult    = rtype(2, 3, 0, 24);
      sysc    = rtype(0, 0, 0, 12);

      do_reset();

      // Load-use: exactly one stall cycle, then the ADD issues.
      base = m_stalls;
      step("lu_lw", lw8, 1, 0, 1, 0);
      step("lu_stall", add_dep, 1, 0, 1, 0);
      step("lu_issue", add_dep, 1, 0, 1, 0);
      check("lu_stall_cnt", 32'(stall_cnt), 32'(base + 1));

      // Load into $0: no stall.
      base = m_stalls;
      step("r0_lw", lw0, 1, 0, 1, 0);
      step("r0_add", add_r0, 1, 0, 1, 0);
      step("r0_next", add_ind, 1, 0, 1, 0);
      check("r0_stall_cnt", 32'(stall_cnt), 32'(base));

      // MULT occupies HI/LO for MULDIV_LAT cycles.
      do_reset();
      step("md_mult", mult, 1, 0, 1, 0);
      for (int i = 0; i < ML + 1; i++) step("md_add", add_ind, 1, 0, 1, 0);
      check("md_stall_cnt", 32'(stall_cnt), 32'(ML));

      // Three-cycle miss freezes, then the held load-use is still seen.
      base = m_stalls;
      step("miss_lw", lw8, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) step("miss_frz", add_dep, 1, 1, 0, 0);
      step("miss_lu", add_dep, 1, 0, 1, 0);
      check("miss_lu_bubble", 32'(id_bubble), 32'd1);
      step("miss_issue", add_dep, 1, 0, 1, 0);
      check("miss_stall_cnt", 32'(stall_cnt), 32'(base + 4));

      // Redirect beats load-use: flush, no bubble, no stall counted.
      base = m_stalls;
      step("rd_lw", lw8, 1, 0, 1, 0);
      step("rd_flush", add_dep, 1, 0, 1, 1);
      check("rd_flush_out", 32'(flush), 32'd1);
      step("rd_after", add_ind, 1, 0, 1, 0);
      check("rd_stall_cnt", 32'(stall_cnt), 32'(base));

      // Miss and redirect together: miss wins.
      step("mr_both", add_ind, 1, 1, 0, 1);
      step("mr_redir", add_ind, 1, 0, 1, 1);

      // SYSCALL: drain PD cycles then sticky halt.
      do_reset();
      step("sys_issue", sysc, 1, 0, 1, 0);
      for (int i = 0; i < PD; i++) begin
         step("sys_drain", add_ind, 1, 0, 1, 0);
         check("sys_not_halted", 32'(halted), 32'd0);
      end
      for (int i = 0; i < 12; i++) begin
         step("sys_halt", add_ind, 1, 0, 1, 0);
         check("sys_halted", 32'(halted), 32'd1);
      end

      // Miss during drain delays halt by the miss length.
      do_reset();
      step("sysm_issue", sysc, 1, 0, 1, 0);
      step("sysm_d0", NOP, 0, 0, 1, 0);
      step("sysm_m0", NOP, 0, 1, 0, 0);
      step("sysm_m1", NOP, 0, 1, 0, 0);
      step("sysm_d1", NOP, 0, 0, 1, 0);
      step("sysm_d2", NOP, 0, 0, 1, 0);
      check("sysm_pre", 32'(halted), 32'd0);
      step("sysm_halt", NOP, 0, 0, 1, 0);
      check("sysm_halted", 32'(halted), 32'd1);

      // Asynchronous reset in the middle of a drain.
      do_reset();
      step("ar_issue", sysc, 1, 0, 1, 0);
      step("ar_d0", NOP, 0, 1, 0, 0);
      @(posedge clk);
      #2 rst_b = 0;
      #1;
      check("ar_halted", 32'(halted), 32'd0);
      check("ar_pc_we", 32'(pc_we), 32'd1);
      check("ar_freeze", 32'(freeze), 32'd0);
      check("ar_stall_cnt", 32'(stall_cnt), 32'd0);
      model_reset();
      @(negedge clk);
      mem_access = 0;
      rst_b = 1;

      // Randomized traffic against the model.
      for (int n = 0; n < 800; n++) begin
         logic [31:0] ins;
         int sel = int'($urandom_range(0, 99));
         int a = int'($urandom_range(0, 7));
         int b = int'($urandom_range(0, 7));
         int c = int'($urandom_range(0, 7));
         if (sel < 25)      ins = rtype(a, b, c, 32);
         else if (sel < 45) ins = itype(($urandom_range(0, 1) != 0) ? 35 : 32, a, b);
         else if (sel < 55) ins = itype(($urandom_range(0, 1) != 0) ? 43 : 4, a, b);
         else if (sel < 65) ins = itype(8 + int'($urandom_range(0, 7)), a, b);
         else if (sel < 70) ins = itype(6, a, b);
         else if (sel < 74) ins = itype(3, a, b);
         else if (sel < 80) ins = rtype(a, b, c, ($urandom_range(0, 1) != 0) ? 24 : 26);
         else if (sel < 84) ins = rtype(a, b, c, 8);
         else if (sel < 85) ins = sysc;
         else               ins = $urandom;
         step("rand", ins, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
         if (m_mode == MHalt && $urandom_range(0, 3) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
